// File: rtl/duty_cycle_meter.sv
// Dual-edge duty-cycle meter: measures rising-to-rising period and high time of sig_in
// in clockin half-cycles, with lock detection and sticky overflow.
module duty_cycle_meter #(
    parameter int CNT_W  = 12,
    parameter int LOCK_N = 4
) (
    input  logic             clockin,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_hc,
    output logic [CNT_W-1:0] high_hc,
    output logic             meas_valid,
    output logic             locked,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic             r_neg_smp;
    logic             r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hcnt;
    logic [3:0]       r_lock_cnt;

    logic             w_rise0;
    logic             w_rise1;
    logic             w_rise;
    logic             w_match;
    logic [CNT_W-1:0] w_ones;
    logic [CNT_W-1:0] w_step;
    logic [CNT_W-1:0] w_start_cnt;
    logic [CNT_W-1:0] w_start_hcnt;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [CNT_W-1:0] w_hcnt_nx;
    logic [CNT_W-1:0] w_per_nx;
    logic [CNT_W-1:0] w_high_nx;
    logic [3:0]       w_lock_nx;
    logic             w_valid_nx;
    logic             w_ovf_nx;

    // Negedge half of the sample stream; consumed together with sig_in at the posedge.
    always_ff @(negedge clockin or posedge reset) begin
        if (reset) r_neg_smp <= 1'b0;
        else       r_neg_smp <= sig_in;
    end

    // Stream order per cycle: r_prev (last posedge sample), r_neg_smp, sig_in.
    // Only one rising edge fits in a cycle, since two would need 0,1,0,1 across three samples.
    always_comb begin
        w_rise0      = r_neg_smp & ~r_prev;
        w_rise1      = sig_in & ~r_neg_smp;
        w_rise       = w_rise0 | w_rise1;
        w_ones       = CNT_W'(r_neg_smp) + CNT_W'(sig_in);
        w_step       = w_rise1 ? CNT_W'(1) : (w_rise0 ? '0 : CNT_W'(2));
        w_start_cnt  = w_rise0 ? CNT_W'(2) : CNT_W'(1);
        w_start_hcnt = w_rise0 ? w_ones : CNT_W'(1);
        w_sum        = {1'b0, r_cnt} + {1'b0, w_step};
        w_match      = (w_sum[CNT_W-1:0] == period_hc) && (r_hcnt == high_hc);
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_hcnt_nx  = r_hcnt;
        w_per_nx   = period_hc;
        w_high_nx  = high_hc;
        w_lock_nx  = r_lock_cnt;
        w_valid_nx = 1'b0;
        w_ovf_nx   = overflow;
        case (r_state)
            IDLE, ARMED: begin
                if (w_rise) begin
                    w_state_nx = MEASURE;
                    w_cnt_nx   = w_start_cnt;
                    w_hcnt_nx  = w_start_hcnt;
                end
            end
            MEASURE: begin
                if (w_sum[CNT_W]) begin
                    w_state_nx = ARMED;
                    w_ovf_nx   = 1'b1;
                    w_lock_nx  = '0;
                    w_cnt_nx   = '0;
                    w_hcnt_nx  = '0;
                end else if (w_rise) begin
                    // High count needs no edge-slot correction: a closing rise in the
                    // posedge slot implies the negedge slot was 0.
                    w_valid_nx = 1'b1;
                    w_per_nx   = w_sum[CNT_W-1:0];
                    w_high_nx  = r_hcnt;
                    w_cnt_nx   = w_start_cnt;
                    w_hcnt_nx  = w_start_hcnt;
                    if ((r_lock_cnt == '0) || !w_match) w_lock_nx = 4'd1;
                    else if (r_lock_cnt != '1)          w_lock_nx = r_lock_cnt + 4'd1;
                end else begin
                    w_cnt_nx  = w_sum[CNT_W-1:0];
                    w_hcnt_nx = r_hcnt + w_ones;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clockin or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_prev     <= 1'b0;
            r_cnt      <= '0;
            r_hcnt     <= '0;
            r_lock_cnt <= '0;
            period_hc  <= '0;
            high_hc    <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_prev     <= sig_in;
            r_cnt      <= w_cnt_nx;
            r_hcnt     <= w_hcnt_nx;
            r_lock_cnt <= w_lock_nx;
            period_hc  <= w_per_nx;
            high_hc    <= w_high_nx;
            meas_valid <= w_valid_nx;
            locked     <= (w_lock_nx >= 4'(LOCK_N));
            overflow   <= w_ovf_nx;
        end
    end

endmodule

// File: tb/tb_duty_cycle_meter.sv
// Scoreboard bench for duty_cycle_meter: a slot-level stream model pushes expected
// measurements; a negedge monitor pops and compares them against meas_valid pulses.
module tb_duty_cycle_meter;

    localparam int CW = 6;
    localparam int LN = 4;

    logic          clockin = 1'b0;
    logic          reset   = 1'b1;
    logic          sig_in  = 1'b0;
    logic [CW-1:0] period_hc;
    logic [CW-1:0] high_hc;
    logic          meas_valid;
    logic          locked;
    logic          overflow;

    duty_cycle_meter #(.CNT_W(CW), .LOCK_N(LN)) u_dut (
        .clockin    (clockin),
        .reset      (reset),
        .sig_in     (sig_in),
        .period_hc  (period_hc),
        .high_hc    (high_hc),
        .meas_valid (meas_valid),
        .locked     (locked),
        .overflow   (overflow)
    );

    always #5 clockin = ~clockin;

    int cyc = 0;
    always @(posedge clockin) cyc <= cyc + 1;

    typedef struct {
        int per;
        int high;
        bit lck;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Stream model state
    bit m_prev = 1'b0;
    bit m_have = 1'b0;
    bit phase  = 1'b0;
    int m_slot = 0;
    int m_last = 0;
    int m_ones = 0;
    int m_lk   = 0;
    int m_pper = 0;
    int m_phigh = 0;

    // Monitor bookkeeping
    int n_pulses     = 0;
    bit lock_phase   = 1'b0;
    int lock_pulses  = 0;
    int lock_rise_at = 0;
    int lock_fall_at = 0;
    int lock_fall_per = 0;
    int ov_cyc       = 0;

    task automatic chk(input string name, input logic [31:0] act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Drive one half-slot value, then wait for the edge that samples it.
    task automatic slot(input bit v);
        exp_t e;
        sig_in = v;
        m_slot++;
        if (v && !m_prev) begin
            if (m_have) begin
                e.per  = m_slot - m_last;
                e.high = m_ones;
                if (m_lk == 0 || e.per != m_pper || e.high != m_phigh) m_lk = 1;
                else if (m_lk < 15) m_lk++;
                e.lck  = (m_lk >= LN);
                e.cyc  = cyc + 1;
                m_pper  = e.per;
                m_phigh = e.high;
                q.push_back(e);
            end
            m_have = 1'b1;
            m_last = m_slot;
            m_ones = 0;
        end
        if (v) m_ones++;
        m_prev = v;
        if (!phase) @(negedge clockin);
        else        @(posedge clockin);
        #1;
        phase = ~phase;
    endtask

    task automatic pattern(input logic [15:0] bits, input int len, input int reps);
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < len; i++)
                slot(bits[len-1-i]);
    endtask

    task automatic do_reset(input bit check);
        #2 reset = 1'b1;
        #1;
        if (check) begin
            chk("rst_period", period_hc, 0);
            chk("rst_high", high_hc, 0);
            chk("rst_valid", meas_valid, 0);
            chk("rst_locked", locked, 0);
            chk("rst_overflow", overflow, 0);
        end
        sig_in  = 1'b0;
        q.delete();
        m_prev  = 1'b0;
        m_have  = 1'b0;
        m_lk    = 0;
        m_pper  = 0;
        m_phigh = 0;
        repeat (2) @(posedge clockin);
        #1 reset = 1'b0;
        phase = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clockin);
            if (!reset) begin
                if (overflow && ov_cyc == 0) ov_cyc = cyc;
                if (meas_valid) begin
                    n_pulses++;
                    if (lock_phase) begin
                        lock_pulses++;
                        if (locked && lock_rise_at == 0) lock_rise_at = lock_pulses;
                        if (!locked && lock_rise_at != 0 && lock_fall_at == 0) begin
                            lock_fall_at  = lock_pulses;
                            lock_fall_per = int'(period_hc);
                        end
                    end
                    if (q.size() == 0) begin
                        chk("unexpected_valid", 1, 0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("pulse_cycle", cyc, e.cyc);
                        chk("period_hc", period_hc, e.per);
                        chk("high_hc", high_hc, e.high);
                        chk("locked", locked, int'(e.lck));
                    end
                end else if (q.size() != 0 && q[0].cyc <= cyc) begin
                    chk("missing_valid", 0, 1);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        int rise_cyc;
        int base;

        // Reset state
        #3;
        chk("init_period", period_hc, 0);
        chk("init_high", high_hc, 0);
        chk("init_valid", meas_valid, 0);
        chk("init_locked", locked, 0);
        chk("init_overflow", overflow, 0);
        @(posedge clockin);
        #1 reset = 1'b0;
        phase = 1'b0;

        // clockin/2 toggled on posedge: 1100...
        pattern(16'b1100, 4, 10);
        chk("div2_period", period_hc, 4);
        chk("div2_high", high_hc, 2);

        // Toggle every half-cycle
        pattern(16'b10, 2, 12);
        chk("half_period", period_hc, 2);
        chk("half_high", high_hc, 1);

        // 9-half-cycle pattern mixing both edges
        pattern(16'b111110000, 9, 8);
        chk("nine_period", period_hc, 9);
        chk("nine_high", high_hc, 5);
        chk("nine_locked", locked, 1);

        // Lock acquisition and loss
        do_reset(1'b0);
        lock_phase = 1'b1;
        pattern(16'b111000, 6, 8);
        chk("lock_held", locked, 1);
        chk("lock_rise_pulse", lock_rise_at, 4);
        pattern(16'b11100000, 8, 3);
        chk("lock_fall_pulse", lock_fall_at, 9);
        chk("lock_fall_period", lock_fall_per, 8);
        chk("lock_lost", locked, 0);
        lock_phase = 1'b0;

        // Asynchronous reset mid-period
        slot(1'b1); slot(1'b1); slot(1'b1); slot(1'b0);
        do_reset(1'b1);
        base = n_pulses;
        pattern(16'b1100, 4, 4);
        chk("post_reset_pulses", n_pulses - base, 3);

        // Overflow with a stuck-high input after lock
        do_reset(1'b0);
        pattern(16'b1100, 4, 6);
        chk("pre_ovf_locked", locked, 1);
        ov_cyc   = 0;
        rise_cyc = cyc + 1;
        for (int i = 0; i < 80; i++) slot(1'b1);
        chk("ovf_set", overflow, 1);
        chk("ovf_locked", locked, 0);
        chk("ovf_latency", (ov_cyc > rise_cyc) && (ov_cyc - rise_cyc <= 32), 1);
        m_have = 1'b0;
        m_lk   = 0;
        pattern(16'b1100, 4, 6);
        chk("ovf_sticky", overflow, 1);
        chk("rearm_period", period_hc, 4);
        chk("rearm_high", high_hc, 2);

        repeat (3) @(negedge clockin);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
